// File: rtl/soc_mem_bridge.sv
// Request/response bridge in front of a single-port soft SRAM with a 2-entry response buffer.
// Define SOC_MEM_BRIDGE_RANGE_CHECK_EN to turn out-of-window accesses into error responses.
module soc_mem_bridge #(
  parameter int unsigned WORD_SIZE_BYTE = 4,
  parameter int unsigned SIZE_IN_KB     = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  localparam int unsigned DEPTH = SIZE_IN_KB * 1024 / WORD_SIZE_BYTE,
  localparam int unsigned AW    = $clog2(DEPTH) + 1,
  localparam int unsigned OFS   = $clog2(WORD_SIZE_BYTE),
  localparam int unsigned DW    = 8 * WORD_SIZE_BYTE
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [31:0]               addr_i,
  input  logic                      we_i,
  input  logic [WORD_SIZE_BYTE-1:0] be_i,
  input  logic [DW-1:0]             wdata_i,
  output logic                      rvalid_o,
  input  logic                      rready_i,
  output logic [DW-1:0]             rdata_o,
  output logic                      err_o,
  output logic                      mem_en_o,
  output logic [AW-1:0]             mem_addr_o,
  output logic [WORD_SIZE_BYTE-1:0] mem_we_o,
  output logic [DW-1:0]             mem_wdata_o,
  input  logic [DW-1:0]             mem_rdata_i
);

  logic [31:0]   offset;
  logic          in_range;
  logic          acc;
  logic          pop;
  logic          push;
  logic          pop_fifo;
  logic          fifo_nonempty;
  logic [1:0]    occ;
  logic [DW-1:0] pend_data;
  logic          head_valid;
  logic [DW-1:0] head_data;
  logic          head_err;

  logic          pend_valid_q, pend_valid_d;
  logic          pend_read_q, pend_read_d;
  logic          pend_err_q, pend_err_d;
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] fifo_data_q [2];
  logic [1:0]    fifo_err_q;

  assign offset = addr_i - BASE_ADDR;

`ifdef SOC_MEM_BRIDGE_RANGE_CHECK_EN
  assign in_range = (offset < 32'(SIZE_IN_KB * 1024));
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    // NOTE: every signal gets a default at the top of the block, so no path can infer a latch.
    fifo_nonempty = (count_q != 2'd0);
    occ           = 2'(pend_valid_q) + count_q;
    // Bypassed pending entry: only an in-range read carries SRAM data.
    pend_data     = (pend_read_q && !pend_err_q) ? mem_rdata_i : '0;
    head_valid    = fifo_nonempty || pend_valid_q;
    head_data     = fifo_nonempty ? fifo_data_q[rd_ptr_q] : pend_data;
    head_err      = fifo_nonempty ? fifo_err_q[rd_ptr_q] : pend_err_q;

    rvalid_o = !rst_i && head_valid;
    pop      = rvalid_o && rready_i;
    gnt_o    = !rst_i && ((occ < 2'd2) || pop);
    acc      = req_i && gnt_o;
    pop_fifo = pop && fifo_nonempty;
    // A pending entry not consumed straight from the bypass path lands in the FIFO.
    push     = pend_valid_q && !(pop && !fifo_nonempty);

    rdata_o     = rvalid_o ? head_data : '0;
    err_o       = rvalid_o && head_err;
    mem_en_o    = acc && in_range;
    mem_we_o    = (acc && we_i && in_range) ? be_i : '0;
    mem_wdata_o = wdata_i;
    mem_addr_o  = AW'(offset >> OFS);

    pend_valid_d = acc;
    pend_read_d  = pend_read_q;
    pend_err_d   = pend_err_q;
    if (acc) begin
      pend_read_d = !we_i;
      pend_err_d  = !in_range;
    end

    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push)     wr_ptr_d = !wr_ptr_q;
    if (pop_fifo) rd_ptr_d = !rd_ptr_q;
    if (push && !pop_fifo)      count_d = count_q + 2'd1;
    else if (!push && pop_fifo) count_d = count_q - 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid_q <= 1'b0;
      pend_read_q  <= 1'b0;
      pend_err_q   <= 1'b0;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_read_q  <= pend_read_d;
      pend_err_q   <= pend_err_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count and pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= pend_data;
      fifo_err_q[wr_ptr_q]  <= pend_err_q;
    end
  end

endmodule

// File: tb/tb_soc_mem_bridge.sv
// Randomized bench for soc_mem_bridge: SRAM stand-in, queue-based reference model, directed pins.
// Follows SOC_MEM_BRIDGE_RANGE_CHECK_EN the same way the design does.
module tb_soc_mem_bridge;

  localparam int unsigned DEPTH     = 2048;
  localparam int unsigned AW        = 12;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam int unsigned WIN_BYTES = 8 * 1024;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int vectors = 0;
  int miscompares = 0;

  soc_mem_bridge #(.WORD_SIZE_BYTE(4), .SIZE_IN_KB(8), .BASE_ADDR(BASE_ADDR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .rdata_o(rdata_o), .err_o(err_o), .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // SRAM stand-in: one-cycle read latency, byte write enables.
  logic [31:0] sram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) sram[i] = '0;
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) sram[int'(mem_addr_o) % DEPTH][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      mem_rdata_i <= sram[int'(mem_addr_o) % DEPTH];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] data; logic err; } rsp_t;
  rsp_t exp_q[$];
  logic [31:0] ref_mem [int];

  function automatic bit model_in_range(input logic [31:0] a);
`ifdef SOC_MEM_BRIDGE_RANGE_CHECK_EN
    return (a - BASE_ADDR) < WIN_BYTES;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(((a - BASE_ADDR) >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return '0;
  endfunction

  always @(negedge clk_i) begin
    bit   acc;
    bit   inr;
    rsp_t r;
    logic [31:0] merged;
    if (rst_i) begin
      check("rst_gnt", gnt_o, 0);
      check("rst_rvalid", rvalid_o, 0);
      check("rst_rdata", rdata_o, 0);
      check("rst_err", err_o, 0);
      check("rst_mem_en", mem_en_o, 0);
      check("rst_mem_we", mem_we_o, 0);
      exp_q.delete();
    end else begin
      // Every queued response is deliverable; at most two may be outstanding.
      check("gnt", gnt_o, (exp_q.size() < 2) || rready_i);
      check("rvalid", rvalid_o, exp_q.size() != 0);
      if (exp_q.size() != 0 && rvalid_o) begin
        check("rdata", rdata_o, exp_q[0].data);
        check("err", err_o, exp_q[0].err);
      end
      acc = req_i && gnt_o;
      inr = model_in_range(addr_i);
      check("mem_en", mem_en_o, acc && inr);
      check("mem_we", mem_we_o, (acc && we_i && inr) ? be_i : 4'h0);
      if (acc && inr) begin
        check("mem_addr", mem_addr_o, AW'((addr_i - BASE_ADDR) >> 2));
        check("mem_wdata", mem_wdata_o, wdata_i);
      end
      if (rvalid_o && rready_i && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) begin
        r.err  = !inr;
        r.data = (!we_i && inr) ? ref_rd(word_of(addr_i)) : 32'h0;
        if (we_i && inr) begin
          merged = ref_rd(word_of(addr_i));
          for (int b = 0; b < 4; b++) if (be_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
          ref_mem[word_of(addr_i)] = merged;
        end
        exp_q.push_back(r);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req_i = r; we_i = w; addr_i = a; be_i = b; wdata_i = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got[$];
    int k;
    int grants;
    rst_i = 1'b1; rready_i = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);

    // Reset with a request held: never granted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("hold_rst_gnt", gnt_o, 0);
      step();
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    check("first_gnt", gnt_o, 1);
    step();

    // Full write then read-after-write.
    drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF); step();
    drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);         step();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk_i);
    check("raw_rvalid", rvalid_o, 1);
    check("raw_rdata", rdata_o, 32'hDEAD_BEEF);
    step();

    // Partial byte write.
    drive(1'b1, 1'b1, 32'h20, 4'hF, 32'h1122_3344); step();
    drive(1'b1, 1'b1, 32'h20, 4'h1, 32'h0000_00AA); step();
    drive(1'b1, 1'b0, 32'h21, 4'h0, 32'h0);         step();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk_i);
    check("partial_rdata", rdata_o, 32'h1122_33AA);
    step();

    // Backpressure: preload words 0..3, then four reads with rready low.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'(4 * i), 4'hF, 32'h100 + 32'(i));
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); step(); step();
    rready_i = 1'b0; k = 0; grants = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 32'(4 * k), 4'h0, 32'h0);
      @(negedge clk_i);
      if (gnt_o) begin grants++; k++; end
      step();
    end
    check("bp_grants", grants, 2);
    rready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive(k < 4, 1'b0, 32'(4 * k), 4'h0, 32'h0);
      @(negedge clk_i);
      if (rvalid_o && rready_i) got.push_back(rdata_o);
      if (gnt_o && req_i) k++;
      step();
    end
    check("bp_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      check("bp_data", (i < got.size()) ? got[i] : 32'hFFFF_FFFF, 32'h100 + 32'(i));

    // Window edge: first byte past the SRAM.
    drive(1'b1, 1'b0, 32'h2000, 4'h0, 32'h0);
    @(negedge clk_i);
`ifdef SOC_MEM_BRIDGE_RANGE_CHECK_EN
    check("oor_mem_en", mem_en_o, 0);
`else
    check("alias_mem_en", mem_en_o, 1);
`endif
    step();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk_i);
    check("edge_rvalid", rvalid_o, 1);
`ifdef SOC_MEM_BRIDGE_RANGE_CHECK_EN
    check("oor_err", err_o, 1);
    check("oor_rdata", rdata_o, 0);
`else
    check("alias_err", err_o, 0);
    check("alias_rdata", rdata_o, 32'h100);
`endif
    step();

    // Reset with two responses outstanding.
    rready_i = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0); step();
    drive(1'b1, 1'b0, 32'h4, 4'h0, 32'h0); step();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst_i = 1'b1; step();
    rst_i = 1'b0; rready_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_rvalid", rvalid_o, 0);
    step();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'h2000 + 32'($urandom_range(0, 15) * 4);
      else a = 32'($urandom_range(0, 31) * 4);
      a = a + 32'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
            4'($urandom_range(0, 15)), $urandom);
      rready_i = ($urandom_range(0, 9) < 7);
      rst_i    = ($urandom_range(0, 249) == 0);
      step();
    end
    rst_i = 1'b0; rready_i = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
